// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer beside EX.
// Produces the HI/LO write data as a one-cycle res_valid pulse and holds the
// front of the pipeline through stallreq while the operation is in flight.
//
// Handshake: an op is taken in IDLE on any cycle with op_valid=1 and annul=0;
// stallreq stays high until the DONE cycle, where res_valid=1 for exactly one
// cycle and the instruction may leave EX. annul (or rst) cancels whatever is
// in flight or being offered, with no res_valid for the cancelled op.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        annul,
  output logic        stallreq,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [5:0]  cnt_q;

  logic        accept;
  logic        src_b_zero;
  logic [31:0] src_a_mag;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvs_mag;
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic        take;
  logic [31:0] step_rem;
  logic [31:0] step_quot;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] prod;

  assign accept     = (state == S_IDLE) && op_valid && !annul;
  assign src_b_zero = (src_b == 32'd0);
  // Dividend magnitude loaded into the quotient shift register at acceptance.
  assign src_a_mag  = (!op_type[0] && src_a[31]) ? (32'd0 - src_a) : src_a;

  // Operand signs only matter for the signed variants (op_q[0]==0).
  assign a_neg   = !op_q[0] && a_q[31];
  assign b_neg   = !op_q[0] && b_q[31];
  assign dvs_mag = b_neg ? (32'd0 - b_q) : b_q;

  // One restoring step: the shifted remainder needs 33 bits before the
  // trial subtraction; the borrow bit decides whether the divisor fits.
  assign rem_sh    = {rem_q, quot_q[31]};
  assign rem_sub   = rem_sh - {1'b0, dvs_mag};
  assign take      = !rem_sub[32];
  assign step_rem  = take ? rem_sub[31:0] : rem_sh[31:0];
  assign step_quot = {quot_q[30:0], take};

  // Sign fix on the final step: quotient negated when signs differ,
  // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
  assign div_quot = (a_neg ^ b_neg) ? (32'd0 - step_quot) : step_quot;
  assign div_rem  = a_neg ? (32'd0 - step_rem) : step_rem;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod   = op_q[0] ? prod_u : prod_s;

  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);
  assign stallreq  = (((state == S_IDLE) && op_valid) || (state == S_MUL) ||
                      (state == S_DIV_RUN)) && !annul;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; annul overrides every transition back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          if (!op_type[1])    state_next = S_MUL;
          else if (src_b_zero) state_next = S_DONE;
          else                 state_next = S_DIV_RUN;
        end
      end
      S_MUL:     state_next = S_DONE;
      S_DIV_RUN: if (cnt_q == 6'd31) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (annul) state_next = S_IDLE;
  end

  // Operand latch, divide iteration and result registers (written only on
  // entry to DONE, so a cancelled op leaves HI/LO untouched).
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= 2'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rem_q       <= 32'd0;
      quot_q      <= 32'd0;
      cnt_q       <= 6'd0;
      hi_out      <= 32'd0;
      lo_out      <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_q   <= op_type;
      a_q    <= src_a;
      b_q    <= src_b;
      rem_q  <= 32'd0;
      quot_q <= src_a_mag;
      cnt_q  <= 6'd0;
      if (op_type[1] && src_b_zero) begin
        hi_out      <= src_a;
        lo_out      <= 32'hFFFF_FFFF;
        div_by_zero <= 1'b1;
      end
    end else if ((state == S_MUL) && !annul) begin
      hi_out      <= prod[63:32];
      lo_out      <= prod[31:0];
      div_by_zero <= 1'b0;
    end else if ((state == S_DIV_RUN) && !annul) begin
      rem_q  <= step_rem;
      quot_q <= step_quot;
      cnt_q  <= cnt_q + 6'd1;
      if (cnt_q == 6'd31) begin
        hi_out      <= div_rem;
        lo_out      <= div_quot;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: table of mul/div vectors plus hand sequences for
// annul, mid-op reset and back-to-back acceptance.
module tb_hilo_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        annul;
  logic        stallreq;
  logic        busy;
  logic        res_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;

  hilo_muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_type     (op_type),
    .src_a       (src_a),
    .src_b       (src_b),
    .annul       (annul),
    .stallreq    (stallreq),
    .busy        (busy),
    .res_valid   (res_valid),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];   // {div_by_zero, hi, lo}
  int          checks = 0;
  int          passes = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Pop and compare on every result pulse.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 64'(res_valid), 64'd0);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("hi_out", 64'(hi_out), 64'(e[63:32]));
        check("lo_out", 64'(lo_out), 64'(e[31:0]));
        check("div_by_zero", 64'(div_by_zero), 64'(e[64]));
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // ---------------- driver ----------------
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dbz,
                        input int lat);
    int   got;
    logic stall_ok;
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = op; src_a = a; src_b = b;
    exp_q.push_back({dbz, hi, lo});
    @(negedge clk);
    check("stall_at_accept", 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    got = 0;
    stall_ok = 1'b1;
    for (int k = 1; k <= lat + 4 && got == 0; k++) begin
      @(negedge clk);
      if (res_valid) begin
        got = k;
        check("stall_low_in_done", 64'(stallreq), 64'd0);
      end else if (!stallreq) begin
        stall_ok = 1'b0;
      end
    end
    check("latency", 64'(got), 64'(lat));
    check("stall_profile", 64'(stall_ok), 64'd1);
    @(negedge clk);
    check("pulse_one_cycle", 64'(res_valid), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    last_hi = hi;
    last_lo = lo;
  endtask

  // ---------------- test ----------------
  initial begin
    int   got;
    logic [6:0] pat;
    logic [31:0] ra;
    logic [31:0] rb;
    longint rp;

    vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2};
    vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 2};
    vecs[2]  = '{2'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 2};
    vecs[3]  = '{2'd1, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0, 2};
    vecs[4]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[5]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[6]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
    vecs[7]  = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1};
    vecs[8]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[9]  = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};
    vecs[10] = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1};
    vecs[11] = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd0,        32'd1,        1'b0, 33};

    // reset
    rst = 1'b1; op_valid = 1'b0; op_type = 2'd0; src_a = 32'd0; src_b = 32'd0; annul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stallreq", 64'(stallreq), 64'd0);

    // table
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);

    // random divu and signed mult against language arithmetic
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = 32'($urandom_range(1, 1000));
      run_op(2'd3, ra, rb, ra % rb, ra / rb, 1'b0, 33);
      ra = $urandom;
      rb = $urandom;
      rp = longint'($signed(ra)) * longint'($signed(rb));
      run_op(2'd0, ra, rb, rp[63:32], rp[31:0], 1'b0, 2);
    end

    // annul at T+10 of a divide, then multu 2x3 at T+11
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 2'd3; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall_drop", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0;
    op_valid = 1'b1; op_type = 2'd1; src_a = 32'd2; src_b = 32'd3;
    exp_q.push_back({1'b0, 32'd0, 32'd6});
    @(negedge clk);
    check("annul_busy_clear", 64'(busy), 64'd0);
    check("annul_hi_kept", 64'(hi_out), 64'(last_hi));
    check("annul_lo_kept", 64'(lo_out), 64'(last_lo));
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("annul_no_result", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("mul_after_annul_t13", 64'(res_valid), 64'd1);
    repeat (40) @(negedge clk);
    check("annul_queue_drained", 64'(exp_q.size()), 64'd0);
    last_hi = 32'd0; last_lo = 32'd6;

    // rst at T+5 of a divide with op_valid held
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 2'd3; src_a = 32'd100; src_b = 32'd7;
    exp_q.push_back({1'b0, 32'd2, 32'd14});
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_hi", 64'(hi_out), 64'd0);
    check("rst_mid_lo", 64'(lo_out), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_res_valid", 64'(res_valid), 64'd0);
    check("rst_reaccept_stall", 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    got = 0;
    for (int k = 7; k <= 45 && got == 0; k++) begin
      @(negedge clk);
      if (res_valid) got = k;
    end
    check("rst_reaccept_latency", 64'(got), 64'd39);

    // back-to-back: op_valid held, results at T+2 and T+5
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 2'd1; src_a = 32'd2; src_b = 32'd3;
    exp_q.push_back({1'b0, 32'd0, 32'd6});
    exp_q.push_back({1'b0, 32'd0, 32'd6});
    pat = 7'd0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 6) op_valid = 1'b0;
      @(negedge clk);
      pat[k] = res_valid;
    end
    check("back_to_back_pattern", 64'(pat), 64'(7'b0100100));
    repeat (5) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that sits beside the EX stage and produces the HI/LO write data carried to WB. It accepts one MULT/MULTU/DIV/DIVU operation, holds the pipeline through the stall controller while it computes, and presents a one-cycle result pulse that EX packs into the lo/hi bus.

## Interface

- No parameters. Data width is fixed at 32 bits, and the product is 64 bits.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  EX holds a mul/div instruction this cycle.
- op_type  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- src_a  in  32  multiplicand or dividend (rs).
- src_b  in  32  multiplier or divisor (rt).
- annul  in  1  flush or exception. Cancels the in-flight or offered operation.
- stallreq  out  1  request to the stall controller to freeze IF..EX.
- busy  out  1  state is not IDLE.
- res_valid  out  1  one-cycle result pulse.
- hi_out  out  32  HI result (product[63:32] or remainder).
- lo_out  out  32  LO result (product[31:0] or quotient).
- div_by_zero  out  1  qualifies res_valid: the divide had src_b==0.

## Operation

- The state machine has four states: IDLE, MUL, DIV_RUN, DONE.
- IDLE:
  - An op is accepted only when op_valid=1 and annul=0. Operands and op_type are latched on acceptance.
  - mult/multu go to MUL.
  - div/divu with src_b!=0 go to DIV_RUN, with the iteration counter (6-bit) loaded to 0.
  - div/divu with src_b==0 go straight to DONE with HI=src_a, LO=32'hFFFFFFFF and div_by_zero=1.
- MUL: the full 64-bit product is computed and registered (signed for mult, unsigned for multu). The next state is DONE.
- DIV_RUN: one restoring-division step per cycle on the operand magnitudes.
  - Each step shifts {rem,quot} left by 1 and subtracts the divisor when rem >= divisor.
  - The state leaves for DONE after the 32nd step (counter==31).
- Sign fix for signed div, applied on entry to DONE:
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- DONE: res_valid=1, and hi_out/lo_out hold the result. The next state is always IDLE. op_valid is ignored in DONE.
- stallreq = ((IDLE & op_valid) | MUL | DIV_RUN) & ~annul.
  - stallreq is low in DONE, so the instruction leaves EX in the same cycle the result is valid.
- annul in any state: the next state is IDLE.
  - No res_valid is produced for the cancelled op.
  - hi_out/lo_out keep their previous values.
  - stallreq drops in the same cycle because it is combinational.
- hi_out/lo_out/div_by_zero update only on entry to DONE and hold until the next DONE.

## Timing

- Reset values: state=IDLE; hi_out=lo_out=0; res_valid=0; busy=0; div_by_zero=0; stallreq=0 while op_valid=0.
- All cycle numbers below count from an op accepted at cycle T (IDLE, op_valid=1).
- Mult: MUL at T+1, DONE/res_valid at T+2. stallreq is high at T and T+1.
- Div, nonzero divisor: DIV_RUN from T+1 to T+32, DONE at T+33. stallreq is high from T to T+32.
- Divide by zero: DONE at T+1. stallreq is high at T only.
- res_valid lasts exactly one cycle. Back-to-back ops: the earliest next acceptance is the cycle after DONE.
- rst mid-operation has the same effect as annul, and additionally clears the outputs to their reset values.

## Test plan

- multu 0xFFFFFFFF × 0xFFFFFFFF: res_valid at T+2 with HI=0xFFFFFFFE, LO=0x00000001. Same test with mult -3 × 5: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div -7 / 2: stallreq high for T..T+32, res_valid at T+33 with LO=0xFFFFFFFD, HI=0xFFFFFFFF. Same test with divu 100 / 7: LO=14, HI=2.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, div_by_zero=0.
- divu 5 / 0: res_valid at T+1 with HI=5, LO=0xFFFFFFFF, div_by_zero=1.
- annul at T+10 of a div: stallreq drops that cycle, busy=0 at T+11, no res_valid, outputs unchanged. A new multu 2×3 at T+11 gives LO=6 at T+13.
- rst at T+5 of a div: all outputs are 0 next cycle. A held op_valid is re-accepted after rst deasserts.
